cmul_pipe: RTL

Parametrised, pipelined successor to the combinational integer/floating-point multiplier. It accepts one operand pair per cycle on a valid/ready handshake. A per-transaction mode bit selects either a 2*INT_W-bit integer product (signed or unsigned) or an IEEE-754 single-precision product. It sits between the operand sequencer and the result writeback, and absorbs backpressure without dropping results.

---
 rtl/cmul_pipe.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmul_pipe.sv
// Three-stage pipelined multiplier: 2*INT_W-bit integer (signed/unsigned) or IEEE-754 single.
// Define CMUL_ROUND_EN for round-to-nearest-even FP results; otherwise FP results truncate.
module cmul_pipe #(
    parameter int INT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic                 in_signed,
    input  logic [INT_W-1:0]     int_a,
    input  logic [INT_W-1:0]     int_b,
    input  logic [31:0]          fp_a,
    input  logic [31:0]          fp_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [2*INT_W-1:0]   int_out,
    output logic [31:0]          fp_out,
    output logic                 fp_ovf,
    output logic                 fp_unf,
    output logic                 fp_nan
);

    localparam int PW = 2 * INT_W;

    logic w_stall;
    logic w_adv;

    // Whole pipe freezes while the result register is held; bubbles move otherwise.
    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    // ---------------- Stage 1: capture and classify ----------------
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;

    assign w_a_zero = (fp_a[30:23] == 8'd0);
    assign w_a_inf  = (fp_a[30:23] == 8'hFF) && (fp_a[22:0] == 23'd0);
    assign w_a_nan  = (fp_a[30:23] == 8'hFF) && (fp_a[22:0] != 23'd0);
    assign w_b_zero = (fp_b[30:23] == 8'd0);
    assign w_b_inf  = (fp_b[30:23] == 8'hFF) && (fp_b[22:0] == 23'd0);
    assign w_b_nan  = (fp_b[30:23] == 8'hFF) && (fp_b[22:0] != 23'd0);

    logic             r1_valid;
    logic             r1_mode;
    logic             r1_signed;
    logic [INT_W-1:0] r1_int_a;
    logic [INT_W-1:0] r1_int_b;
    logic             r1_sa;
    logic             r1_sb;
    logic [7:0]       r1_ea;
    logic [7:0]       r1_eb;
    logic [23:0]      r1_ma;
    logic [23:0]      r1_mb;
    logic             r1_a_zero, r1_a_inf, r1_a_nan;
    logic             r1_b_zero, r1_b_inf, r1_b_nan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r1_mode   <= 1'b0;
            r1_signed <= 1'b0;
            r1_int_a  <= '0;
            r1_int_b  <= '0;
            r1_sa     <= 1'b0;
            r1_sb     <= 1'b0;
            r1_ea     <= 8'd0;
            r1_eb     <= 8'd0;
            r1_ma     <= 24'd0;
            r1_mb     <= 24'd0;
            r1_a_zero <= 1'b0;
            r1_a_inf  <= 1'b0;
            r1_a_nan  <= 1'b0;
            r1_b_zero <= 1'b0;
            r1_b_inf  <= 1'b0;
            r1_b_nan  <= 1'b0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r1_mode   <= in_mode;
            r1_signed <= in_signed;
            r1_int_a  <= int_a;
            r1_int_b  <= int_b;
            r1_sa     <= fp_a[31];
            r1_sb     <= fp_b[31];
            r1_ea     <= fp_a[30:23];
            r1_eb     <= fp_b[30:23];
            r1_ma     <= {1'b1, fp_a[22:0]};
            r1_mb     <= {1'b1, fp_b[22:0]};
            r1_a_zero <= w_a_zero;
            r1_a_inf  <= w_a_inf;
            r1_a_nan  <= w_a_nan;
            r1_b_zero <= w_b_zero;
            r1_b_inf  <= w_b_inf;
            r1_b_nan  <= w_b_nan;
        end
    end

    // ---------------- Stage 2: multiply ----------------
    logic [PW-1:0]      w_ext_a;
    logic [PW-1:0]      w_ext_b;
    logic [PW-1:0]      w_int_prod;
    logic [47:0]        w_sig_prod;
    logic signed [9:0]  w_exp_sum;

    assign w_ext_a    = r1_signed ? {{INT_W{r1_int_a[INT_W-1]}}, r1_int_a} : {{INT_W{1'b0}}, r1_int_a};
    assign w_ext_b    = r1_signed ? {{INT_W{r1_int_b[INT_W-1]}}, r1_int_b} : {{INT_W{1'b0}}, r1_int_b};
    assign w_int_prod = w_ext_a * w_ext_b;
    assign w_sig_prod = {24'd0, r1_ma} * {24'd0, r1_mb};
    assign w_exp_sum  = $signed({2'b00, r1_ea}) + $signed({2'b00, r1_eb}) - 10'sd127;

    logic              r2_valid;
    logic              r2_mode;
    logic [PW-1:0]     r2_int_prod;
    logic [47:0]       r2_sig;
    logic signed [9:0] r2_exp;
    logic              r2_sign;
    logic              r2_nan;
    logic              r2_inf;
    logic              r2_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_mode     <= 1'b0;
            r2_int_prod <= '0;
            r2_sig      <= 48'd0;
            r2_exp      <= 10'sd0;
            r2_sign     <= 1'b0;
            r2_nan      <= 1'b0;
            r2_inf      <= 1'b0;
            r2_zero     <= 1'b0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_mode     <= r1_mode;
            r2_int_prod <= w_int_prod;
            r2_sig      <= w_sig_prod;
            r2_exp      <= w_exp_sum;
            r2_sign     <= r1_sa ^ r1_sb;
            r2_nan      <= r1_a_nan | r1_b_nan | (r1_a_inf & r1_b_zero) | (r1_a_zero & r1_b_inf);
            r2_inf      <= r1_a_inf | r1_b_inf;
            r2_zero     <= r1_a_zero | r1_b_zero;
        end
    end

    // ---------------- Stage 3: normalise, round, pack ----------------
    logic [22:0]       w_frac_n;
    logic signed [9:0] w_exp_n;
    logic [22:0]       w_frac_f;
    logic signed [9:0] w_exp_f;

    always_comb begin
        if (r2_sig[47]) begin
            w_frac_n = r2_sig[46:24];
            w_exp_n  = r2_exp + 10'sd1;
        end else begin
            w_frac_n = r2_sig[45:23];
            w_exp_n  = r2_exp;
        end
    end

`ifdef CMUL_ROUND_EN
    logic        w_guard;
    logic        w_round;
    logic        w_sticky;
    logic        w_round_up;
    logic [24:0] w_mant_r;

    always_comb begin
        if (r2_sig[47]) begin
            w_guard  = r2_sig[23];
            w_round  = r2_sig[22];
            w_sticky = |r2_sig[21:0];
        end else begin
            w_guard  = r2_sig[22];
            w_round  = r2_sig[21];
            w_sticky = |r2_sig[20:0];
        end
        w_round_up = w_guard & (w_round | w_sticky | w_frac_n[0]);
        w_mant_r   = {2'b01, w_frac_n} + {24'd0, w_round_up};
        // Carry out of the significand: value is exactly 2.0, so fraction becomes zero.
        if (w_mant_r[24]) begin
            w_frac_f = w_mant_r[23:1];
            w_exp_f  = w_exp_n + 10'sd1;
        end else begin
            w_frac_f = w_mant_r[22:0];
            w_exp_f  = w_exp_n;
        end
    end
`else
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^r2_sig[22:0];
    assign w_frac_f      = w_frac_n;
    assign w_exp_f       = w_exp_n;
`endif

    logic [31:0] w_fp_res;
    logic        w_ovf;
    logic        w_unf;
    logic        w_nan;

    always_comb begin
        w_fp_res = 32'd0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_nan    = 1'b0;
        if (r2_nan) begin
            w_fp_res = 32'h7FC0_0000;
            w_nan    = 1'b1;
        end else if (r2_inf) begin
            w_fp_res = {r2_sign, 8'hFF, 23'd0};
        end else if (r2_zero) begin
            w_fp_res = {r2_sign, 31'd0};
        end else if (w_exp_f >= 10'sd255) begin
            w_fp_res = {r2_sign, 8'hFF, 23'd0};
            w_ovf    = 1'b1;
        end else if (w_exp_f <= 10'sd0) begin
            w_fp_res = {r2_sign, 31'd0};
            w_unf    = 1'b1;
        end else begin
            w_fp_res = {r2_sign, w_exp_f[7:0], w_frac_f};
        end
    end

    logic          r_out_valid;
    logic          r_out_mode;
    logic [PW-1:0] r_int_out;
    logic [31:0]   r_fp_out;
    logic          r_fp_ovf;
    logic          r_fp_unf;
    logic          r_fp_nan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_int_out   <= '0;
            r_fp_out    <= 32'd0;
            r_fp_ovf    <= 1'b0;
            r_fp_unf    <= 1'b0;
            r_fp_nan    <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_out_mode  <= r2_mode;
            if (r2_mode) begin
                r_int_out <= '0;
                r_fp_out  <= w_fp_res;
                r_fp_ovf  <= w_ovf;
                r_fp_unf  <= w_unf;
                r_fp_nan  <= w_nan;
            end else begin
                r_int_out <= r2_int_prod;
                r_fp_out  <= 32'd0;
                r_fp_ovf  <= 1'b0;
                r_fp_unf  <= 1'b0;
                r_fp_nan  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_mode  = r_out_mode;
    assign int_out   = r_int_out;
    assign fp_out    = r_fp_out;
    assign fp_ovf    = r_fp_ovf;
    assign fp_unf    = r_fp_unf;
    assign fp_nan    = r_fp_nan;

endmodule
